// File: rtl/temp_pkg.sv
// rtl/temp_pkg.sv - shared types and constants for the multichannel temperature register
// Provides default widths, the physical sample range (-40.0..85.0 C in tenths) and temp_t.
package temp_pkg;

    localparam int N_CANALES_DEF      = 4;
    localparam int ANCHO_TEMP_DEF     = 11;
    localparam int ANCHO_CNT_DEF      = 3;
    localparam int UMBRAL_PERSIST_DEF = 5;

    // Tenths of a degree Celsius.
    localparam int TEMP_MIN_C = -400;
    localparam int TEMP_MAX_C = 850;

    // Sample type at the default width; channels with other widths use plain vectors.
    typedef logic signed [ANCHO_TEMP_DEF-1:0] temp_t;

endpackage

// File: rtl/canal_temp.sv
// rtl/canal_temp.sv - one temperature channel: register, range compare, persistence, alarm
// Ports: clk, arst_n (sync, active-low), temp_entrada/dato_valido sample in, lim_inf/lim_sup
// inclusive limits, borrar_alarma clear; outputs temp_registrado, fuera_rango, contador, alarma.
// Optional (TEMP_MINMAX_EN): borrar_minmax in, temp_min/temp_max out.
module canal_temp
    import temp_pkg::*;
#(
    parameter int ANCHO_TEMP     = ANCHO_TEMP_DEF,
    parameter int ANCHO_CNT      = ANCHO_CNT_DEF,
    parameter int UMBRAL_PERSIST = UMBRAL_PERSIST_DEF
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic [ANCHO_TEMP-1:0] temp_entrada,
    input  logic                  dato_valido,
    input  logic [ANCHO_TEMP-1:0] lim_inf,
    input  logic [ANCHO_TEMP-1:0] lim_sup,
    input  logic                  borrar_alarma,
`ifdef TEMP_MINMAX_EN
    input  logic                  borrar_minmax,
    output logic [ANCHO_TEMP-1:0] temp_min,
    output logic [ANCHO_TEMP-1:0] temp_max,
`endif
    output logic [ANCHO_TEMP-1:0] temp_registrado,
    output logic                  fuera_rango,
    output logic [ANCHO_CNT-1:0]  contador,
    output logic                  alarma
);

    localparam logic [ANCHO_CNT-1:0] CNT_MAX  = '1;
    localparam logic [ANCHO_CNT-1:0] UMBRAL_C = ANCHO_CNT'(UMBRAL_PERSIST);

    if (UMBRAL_PERSIST < 1 || UMBRAL_PERSIST > (2**ANCHO_CNT) - 1) begin : g_umbral_invalido
        $error("UMBRAL_PERSIST out of range 1..2**ANCHO_CNT-1");
    end

    logic                 fuera_nxt;
    logic [ANCHO_CNT-1:0] cnt_nxt;

    // Limits are inclusive; an inverted window makes every sample out of range naturally.
    assign fuera_nxt = ($signed(temp_entrada) < $signed(lim_inf)) ||
                       ($signed(temp_entrada) > $signed(lim_sup));

    always_comb begin
        cnt_nxt = '0;
        if (fuera_nxt) begin
            cnt_nxt = (contador == CNT_MAX) ? contador : contador + ANCHO_CNT'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            temp_registrado <= '0;
            fuera_rango     <= 1'b0;
            contador        <= '0;
            alarma          <= 1'b0;
        end else begin
            if (dato_valido) begin
                temp_registrado <= temp_entrada;
                fuera_rango     <= fuera_nxt;
                contador        <= cnt_nxt;
            end
            // Set beats clear; the alarm can only be (re)armed by a fresh valid sample.
            if (dato_valido && (cnt_nxt >= UMBRAL_C)) begin
                alarma <= 1'b1;
            end else if (borrar_alarma) begin
                alarma <= 1'b0;
            end
        end
    end

`ifdef TEMP_MINMAX_EN
    localparam logic [ANCHO_TEMP-1:0] MAS_POSITIVO = {1'b0, {(ANCHO_TEMP-1){1'b1}}};
    localparam logic [ANCHO_TEMP-1:0] MAS_NEGATIVO = {1'b1, {(ANCHO_TEMP-1){1'b0}}};

    always_ff @(posedge clk) begin
        if (!arst_n || borrar_minmax) begin
            temp_min <= MAS_POSITIVO;
            temp_max <= MAS_NEGATIVO;
        end else if (dato_valido) begin
            if ($signed(temp_entrada) < $signed(temp_min)) temp_min <= temp_entrada;
            if ($signed(temp_entrada) > $signed(temp_max)) temp_max <= temp_entrada;
        end
    end
`endif

endmodule

// File: rtl/registro_temp_multicanal.sv
// rtl/registro_temp_multicanal.sv - N-channel temperature register with persistence alarms
// Ports: clk, arst_n (sync, active-low); packed per-channel temp_entrada, dato_valido,
// borrar_alarma; shared lim_inf/lim_sup; outputs temp_registrado, fuera_rango,
// contador_fuera_rango, alarma, alarma_global. Macro TEMP_MINMAX_EN adds borrar_minmax,
// temp_min, temp_max.
module registro_temp_multicanal
    import temp_pkg::*;
#(
    parameter int N_CANALES      = N_CANALES_DEF,
    parameter int ANCHO_TEMP     = ANCHO_TEMP_DEF,
    parameter int ANCHO_CNT      = ANCHO_CNT_DEF,
    parameter int UMBRAL_PERSIST = UMBRAL_PERSIST_DEF
) (
    input  logic                            clk,
    input  logic                            arst_n,
    input  logic [N_CANALES*ANCHO_TEMP-1:0] temp_entrada,
    input  logic [N_CANALES-1:0]            dato_valido,
    input  logic [ANCHO_TEMP-1:0]           lim_inf,
    input  logic [ANCHO_TEMP-1:0]           lim_sup,
    input  logic [N_CANALES-1:0]            borrar_alarma,
`ifdef TEMP_MINMAX_EN
    input  logic                            borrar_minmax,
    output logic [N_CANALES*ANCHO_TEMP-1:0] temp_min,
    output logic [N_CANALES*ANCHO_TEMP-1:0] temp_max,
`endif
    output logic [N_CANALES*ANCHO_TEMP-1:0] temp_registrado,
    output logic [N_CANALES-1:0]            fuera_rango,
    output logic [N_CANALES*ANCHO_CNT-1:0]  contador_fuera_rango,
    output logic [N_CANALES-1:0]            alarma,
    output logic                            alarma_global
);

    for (genvar i = 0; i < N_CANALES; i++) begin : g_canal
        canal_temp #(
            .ANCHO_TEMP     (ANCHO_TEMP),
            .ANCHO_CNT      (ANCHO_CNT),
            .UMBRAL_PERSIST (UMBRAL_PERSIST)
        ) u_canal (
            .clk             (clk),
            .arst_n          (arst_n),
            .temp_entrada    (temp_entrada[i*ANCHO_TEMP +: ANCHO_TEMP]),
            .dato_valido     (dato_valido[i]),
            .lim_inf         (lim_inf),
            .lim_sup         (lim_sup),
            .borrar_alarma   (borrar_alarma[i]),
`ifdef TEMP_MINMAX_EN
            .borrar_minmax   (borrar_minmax),
            .temp_min        (temp_min[i*ANCHO_TEMP +: ANCHO_TEMP]),
            .temp_max        (temp_max[i*ANCHO_TEMP +: ANCHO_TEMP]),
`endif
            .temp_registrado (temp_registrado[i*ANCHO_TEMP +: ANCHO_TEMP]),
            .fuera_rango     (fuera_rango[i]),
            .contador        (contador_fuera_rango[i*ANCHO_CNT +: ANCHO_CNT]),
            .alarma          (alarma[i])
        );
    end

    assign alarma_global = |alarma;

endmodule

// File: tb/tb_registro_temp_multicanal.sv
// tb/tb_registro_temp_multicanal.sv - directed self-checking bench for registro_temp_multicanal
module tb_registro_temp_multicanal;

    localparam int N = 4;
    localparam int W = 11;
    localparam int C = 3;

    logic             clk = 1'b0;
    logic             arst_n;
    logic [N*W-1:0]   temp_entrada;
    logic [N-1:0]     dato_valido;
    logic [W-1:0]     lim_inf;
    logic [W-1:0]     lim_sup;
    logic [N-1:0]     borrar_alarma;
    logic [N*W-1:0]   temp_registrado;
    logic [N-1:0]     fuera_rango;
    logic [N*C-1:0]   contador_fuera_rango;
    logic [N-1:0]     alarma;
    logic             alarma_global;
`ifdef TEMP_MINMAX_EN
    logic             borrar_minmax;
    logic [N*W-1:0]   temp_min;
    logic [N*W-1:0]   temp_max;
`endif

    int n_checks = 0;
    int n_ok     = 0;

    registro_temp_multicanal #(
        .N_CANALES      (N),
        .ANCHO_TEMP     (W),
        .ANCHO_CNT      (C),
        .UMBRAL_PERSIST (5)
    ) dut (
        .clk                  (clk),
        .arst_n               (arst_n),
        .temp_entrada         (temp_entrada),
        .dato_valido          (dato_valido),
        .lim_inf              (lim_inf),
        .lim_sup              (lim_sup),
        .borrar_alarma        (borrar_alarma),
`ifdef TEMP_MINMAX_EN
        .borrar_minmax        (borrar_minmax),
        .temp_min             (temp_min),
        .temp_max             (temp_max),
`endif
        .temp_registrado      (temp_registrado),
        .fuera_rango          (fuera_rango),
        .contador_fuera_rango (contador_fuera_rango),
        .alarma               (alarma),
        .alarma_global        (alarma_global)
    );

    always #5 clk = ~clk;

    task automatic comprobar(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs === exp) n_ok++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic poner(input int ch, input int val);
        temp_entrada[ch*W +: W] = W'(val);
    endtask

    function automatic int t_reg(input int ch);
        return int'($signed(temp_registrado[ch*W +: W]));
    endfunction

    function automatic int cnt(input int ch);
        return int'(contador_fuera_rango[ch*C +: C]);
    endfunction

    // Drive one valid sample on a channel for a single edge.
    task automatic muestra(input int ch, input int val);
        poner(ch, val);
        dato_valido[ch] = 1'b1;
        tick();
        dato_valido[ch] = 1'b0;
    endtask

    initial begin
        arst_n        = 1'b0;
        temp_entrada  = '0;
        dato_valido   = '0;
        lim_inf       = W'(-400);
        lim_sup       = W'(850);
        borrar_alarma = '0;
`ifdef TEMP_MINMAX_EN
        borrar_minmax = 1'b0;
`endif
        // Reset with random activity on every input.
        for (int k = 0; k < 4; k++) begin
            temp_entrada  = {$urandom, $urandom};
            dato_valido   = N'($urandom);
            borrar_alarma = N'($urandom);
            tick();
        end
        comprobar("rst_temp_reg", int'(temp_registrado == '0), 1);
        comprobar("rst_fuera", int'(fuera_rango), 0);
        comprobar("rst_cnt", int'(contador_fuera_rango == '0), 1);
        comprobar("rst_alarma", int'(alarma), 0);
        comprobar("rst_global", int'(alarma_global), 0);
`ifdef TEMP_MINMAX_EN
        comprobar("rst_min", int'($signed(temp_min[3*W +: W])), 1023);
        comprobar("rst_max", int'($signed(temp_max[3*W +: W])), -1024);
`endif

        temp_entrada  = '0;
        dato_valido   = '0;
        borrar_alarma = '0;
        lim_inf       = W'(-400);
        lim_sup       = W'(850);
        arst_n        = 1'b1;
        tick();

        // Inclusive limits on channel 0.
        muestra(0, 850);
        comprobar("ch0_850_reg", t_reg(0), 850);
        comprobar("ch0_850_fuera", int'(fuera_rango[0]), 0);
        comprobar("ch0_850_cnt", cnt(0), 0);
        muestra(0, -400);
        comprobar("ch0_m400_reg", t_reg(0), -400);
        comprobar("ch0_m400_fuera", int'(fuera_rango[0]), 0);
        muestra(0, 851);
        comprobar("ch0_851_fuera", int'(fuera_rango[0]), 1);
        comprobar("ch0_851_cnt", cnt(0), 1);

        // Persistence on channel 1.
        for (int k = 1; k <= 4; k++) begin
            muestra(1, 900);
            comprobar("ch1_cnt_ramp", cnt(1), k);
        end
        comprobar("ch1_alarma_4", int'(alarma[1]), 0);
        comprobar("global_4", int'(alarma_global), 0);
        muestra(1, 900);
        comprobar("ch1_cnt_5", cnt(1), 5);
        comprobar("ch1_alarma_5", int'(alarma[1]), 1);
        comprobar("global_5", int'(alarma_global), 1);
        muestra(1, 900);
        muestra(1, 900);
        comprobar("ch1_cnt_7", cnt(1), 7);
        muestra(1, 900);
        comprobar("ch1_cnt_sat", cnt(1), 7);
        muestra(1, 20);
        comprobar("ch1_cnt_back0", cnt(1), 0);
        comprobar("ch1_alarma_held", int'(alarma[1]), 1);

        // Clear with cnt=0.
        borrar_alarma[1] = 1'b1;
        tick();
        borrar_alarma[1] = 1'b0;
        comprobar("ch1_clear", int'(alarma[1]), 0);
        comprobar("global_clear", int'(alarma_global), 0);

        // Clear racing the set: set wins.
        for (int k = 0; k < 4; k++) muestra(1, 900);
        borrar_alarma[1] = 1'b1;
        muestra(1, 900);
        borrar_alarma[1] = 1'b0;
        comprobar("race_cnt", cnt(1), 5);
        comprobar("race_alarma", int'(alarma[1]), 1);

        // Clear with cnt still high, then a new out-of-range sample re-arms.
        borrar_alarma[1] = 1'b1;
        tick();
        borrar_alarma[1] = 1'b0;
        comprobar("clear_hi_alarma", int'(alarma[1]), 0);
        comprobar("clear_hi_cnt", cnt(1), 5);
        muestra(1, -500);
        comprobar("rearm_alarma", int'(alarma[1]), 1);
        comprobar("rearm_cnt", cnt(1), 6);

        // Gaps on channel 2: state holds while valid is low.
        muestra(2, 900);
        poner(2, 0);
        for (int k = 0; k < 10; k++) tick();
        comprobar("gap_cnt_hold", cnt(2), 1);
        comprobar("gap_reg_hold", t_reg(2), 900);
        muestra(2, 900);
        comprobar("gap_cnt_2", cnt(2), 2);

`ifdef TEMP_MINMAX_EN
        muestra(3, 100);
        muestra(3, -50);
        muestra(3, 300);
        comprobar("mm_min", int'($signed(temp_min[3*W +: W])), -50);
        comprobar("mm_max", int'($signed(temp_max[3*W +: W])), 300);
        borrar_minmax = 1'b1;
        muestra(3, 5);
        borrar_minmax = 1'b0;
        comprobar("mm_clr_min", int'($signed(temp_min[3*W +: W])), 1023);
        comprobar("mm_clr_max", int'($signed(temp_max[3*W +: W])), -1024);
`endif

        // Inverted window: everything is out of range.
        lim_inf = W'(100);
        lim_sup = W'(0);
        muestra(3, 50);
        comprobar("inv_fuera", int'(fuera_rango[3]), 1);
        comprobar("inv_cnt", cnt(3), 1);
        lim_inf = W'(-400);
        lim_sup = W'(850);

        // All channels strobing together.
        poner(0, 0); poner(1, 900); poner(2, -401); poner(3, 850);
        dato_valido = '1;
        tick();
        dato_valido = '0;
        comprobar("all_fuera", int'(fuera_rango), 4'b0110);
        comprobar("all_cnt0", cnt(0), 0);
        comprobar("all_cnt2", cnt(2), 3);

        // Reset mid-operation overrides a pending set.
        poner(1, 900);
        dato_valido   = '1;
        borrar_alarma = '1;
        arst_n        = 1'b0;
        tick();
        comprobar("mid_rst_alarma", int'(alarma), 0);
        comprobar("mid_rst_cnt", int'(contador_fuera_rango == '0), 1);
        comprobar("mid_rst_global", int'(alarma_global), 0);
        arst_n        = 1'b1;
        dato_valido   = '0;
        borrar_alarma = '0;
        tick();

        $display("%0d/%0d checks passed", n_ok, n_checks);
        $finish;
    end

endmodule
